cmd_response_tx: RTL and testbench
==================================

// Module: cmd_response_tx
// PURPOSE
// - Response framer for the UART command protocol; the transmit-side counterpart of the command parser.
// - Takes one response (opcode + 0..MAX_PAYLOAD bytes) and emits the frame byte-by-byte to uart_tx.
// - Uses uart_tx's strobe/tx_done handshake. Runs on the 10 MHz UART clock domain.
// - Frame: SYNC, OPCODE, LEN, PAYLOAD[0..LEN-1], CSUM, where CSUM = OPCODE ^ LEN ^ all payload bytes.
// PARAMETERS
// - MAX_PAYLOAD  8     : maximum payload bytes per frame (1..15).
// - SYNC_BYTE    8'hA5 : frame start marker.
// - TX_TIMEOUT   20000 : clk cycles to wait for i_tx_done before aborting (2 ms at 10 MHz).
// PORTS
// - clk            in   1                : UART-domain clock; everything is synchronous to its rising edge.
// - reset          in   1                : synchronous, active-high reset.
// - i_start        in   1                : 1-cycle request; sampled only while idle.
// - i_opcode       in   8                : response opcode; captured on accepted i_start.
// - i_len          in   4                : payload byte count; captured on accepted i_start.
// - i_payload      in   MAX_PAYLOAD*8    : payload; byte k = [8k+7:8k]; byte 0 is sent first; captured on accepted i_start.
// - o_busy         out  1                : high from the cycle after an accepted i_start until o_done or o_error.
// - o_done         out  1                : 1-cycle pulse after CSUM's i_tx_done.
// - o_error        out  1                : 1-cycle pulse on timeout abort.
// - o_tx_strobe    out  1                : 1-cycle byte-valid strobe to uart_tx (its tx_dv input).
// - o_wr_byte      out  8                : byte to uart_tx; stable from the strobe until the matching i_tx_done.
// - i_tx_done      in   1                : 1-cycle pulse from uart_tx when the byte's stop bit finishes.
// BEHAVIOUR
// - Reset values: all outputs 0, o_wr_byte 8'h00, state IDLE, checksum 0, counters 0.
// - States: IDLE -> STROBE -> WAIT -> (STROBE | FINISH) -> IDLE; any state -> ABORT -> IDLE on timeout.
// - IDLE, i_start=1:
//   - Latch opcode, len and payload; clamp len to MAX_PAYLOAD if i_len > MAX_PAYLOAD; clear checksum.
//   - Byte index = 0; go to STROBE.
// - IDLE, i_start=0: stay in IDLE.
// - STROBE (1 cycle):
//   - Drive o_tx_strobe=1 and o_wr_byte = frame byte at the current index.
//   - Fold the byte into the checksum, except SYNC and CSUM itself.
//   - Clear the timeout counter; go to WAIT.
// - WAIT:
//   - On i_tx_done, if the byte was CSUM, go to FINISH; otherwise index+1 and go to STROBE.
//   - On i_tx_done there is exactly 1 idle cycle between i_tx_done and the next o_tx_strobe.
//   - Otherwise increment the timeout counter; on reaching TX_TIMEOUT-1, go to ABORT.
// - FINISH: o_done=1 for 1 cycle; o_busy drops in the same cycle; return to IDLE.
// - ABORT: o_error=1 for 1 cycle; o_busy drops; no further strobes; return to IDLE.
// - Frame length = 4 + len bytes; len=0 gives SYNC, OPCODE, 00, CSUM with CSUM = OPCODE.
// - Checksum: 8-bit XOR accumulator; no carry or width growth.
// - Index counter: width clog2(MAX_PAYLOAD+4); never wraps within a frame.
// - Latency: o_tx_strobe for SYNC is 2 cycles after the accepted i_start (IDLE->STROBE register, then strobe).
// - i_start while o_busy=1: ignored, not queued; latched fields stay unchanged.
// - i_tx_done seen in IDLE or STROBE: ignored; it never advances the index.
// - i_tx_done and timeout expiry in the same cycle: i_tx_done wins.
// - reset mid-frame: immediate return to IDLE, outputs to reset values.
//   - Any byte already inside uart_tx finishes on the line; its late i_tx_done is ignored in IDLE.
// STRUCTURE
// - Shared header cmd_proto.vh (also included by the command parser):
//   - `CMD_SYNC_BYTE
//   - response opcode defines (ACK 8'h01, NAK 8'h02, STATUS 8'h10)
//   - frame field offsets
// - Single module, no sub-module; the byte mux selects among {SYNC, opcode, len, payload[idx-3], csum}.
// - Synthesis target: one FSM, one index counter, one timeout counter, one checksum register.
// TESTING
// - Bench models uart_tx: i_tx_done pulses 1000 clk after each o_tx_strobe.
// - T1 ACK, len 0, opcode 8'h01:
//   - 4 strobes with bytes A5,01,00,01.
//   - o_done 1 cycle after the 4th i_tx_done; o_busy low afterwards.
// - T2 STATUS, len 3, payload bytes 11,22,33:
//   - bytes A5,10,03,11,22,33,CSUM; CSUM = 10^03^11^22^33 = 8'h13.
//   - exactly 1 idle cycle between each i_tx_done and the next strobe.
// - T3 i_len=4'hF with MAX_PAYLOAD=8:
//   - LEN byte sent as 08; 12 strobes total; checksum covers 8 payload bytes.
// - T4 second i_start 5 cycles into frame T2 with opcode 8'h02:
//   - ignored; the T2 byte stream is unchanged and no extra frame follows.
// - T5 bench withholds i_tx_done after the OPCODE byte:
//   - o_error pulses exactly TX_TIMEOUT cycles after that strobe; no further strobes.
//   - a new i_start afterwards produces a full, correct frame.
// - T6 reset asserted for 1 cycle while waiting for payload byte 1's i_tx_done:
//   - all outputs 0 next cycle; the late i_tx_done produces no strobe.
//   - a following i_start yields a frame starting with A5.

Source files
------------

// File: rtl/cmd_response_tx_pkg.sv
// Shared protocol constants for the UART command link: sync marker, response opcodes,
// frame field offsets, framer state encoding and the checksum fold helper.
package cmd_response_tx_pkg;

    localparam logic [7:0] CMD_SYNC_BYTE = 8'hA5;

    localparam logic [7:0] CMD_OP_ACK    = 8'h01;
    localparam logic [7:0] CMD_OP_NAK    = 8'h02;
    localparam logic [7:0] CMD_OP_STATUS = 8'h10;

    // Byte positions within a frame; payload starts at FRM_OFF_PAYLOAD, CSUM follows it.
    localparam int FRM_OFF_SYNC    = 0;
    localparam int FRM_OFF_OPCODE  = 1;
    localparam int FRM_OFF_LEN     = 2;
    localparam int FRM_OFF_PAYLOAD = 3;
    localparam int FRM_OVERHEAD    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE,
        ST_WAIT,
        ST_FINISH,
        ST_ABORT
    } tx_state_e;

    function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/cmd_response_tx.sv
// Response framer: SYNC/OPCODE/LEN/PAYLOAD/CSUM byte stream to uart_tx; first strobe 2 clk after start.
// Paced by uart_tx's tx_done (1 idle clk between done and next strobe); aborts with o_error on timeout.
module cmd_response_tx
    import cmd_response_tx_pkg::*;
#(
    parameter int         MAX_PAYLOAD = 8,
    parameter logic [7:0] SYNC_BYTE   = CMD_SYNC_BYTE,
    parameter int         TX_TIMEOUT  = 20000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_start,
    input  logic [7:0]               i_opcode,
    input  logic [3:0]               i_len,
    input  logic [MAX_PAYLOAD*8-1:0] i_payload,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_error,
    output logic                     o_tx_strobe,
    output logic [7:0]               o_wr_byte,
    input  logic                     i_tx_done
);

    localparam int         IDX_W   = $clog2(MAX_PAYLOAD + FRM_OVERHEAD);
    localparam int         TMO_W   = (TX_TIMEOUT > 2) ? $clog2(TX_TIMEOUT) : 1;
    localparam logic [3:0] LEN_MAX = 4'(MAX_PAYLOAD);

    tx_state_e               r_state;
    tx_state_e               w_next;

    logic [7:0]               r_opcode;
    logic [3:0]               r_len;
    logic [MAX_PAYLOAD*8-1:0] r_payload;
    logic [IDX_W-1:0]         r_idx;
    logic [7:0]               r_csum;
    logic [TMO_W-1:0]         r_tmo;

    logic                     r_busy;
    logic                     r_done;
    logic                     r_error;
    logic                     r_tx_strobe;
    logic [7:0]               r_wr_byte;

    logic [IDX_W-1:0]         w_last_idx;
    logic                     w_is_last;
    logic                     w_tmo_hit;
    logic                     w_fold;
    logic [7:0]               w_pay_byte;
    logic [7:0]               w_frame_byte;

    assign w_last_idx = IDX_W'(r_len) + IDX_W'(FRM_OVERHEAD - 1);
    assign w_is_last  = (r_idx == w_last_idx);
    assign w_tmo_hit  = (r_tmo == TMO_W'(TX_TIMEOUT - 1));
    assign w_fold     = (r_idx != IDX_W'(FRM_OFF_SYNC)) && !w_is_last;

    // CSUM is tested before payload so a zero-length frame puts the checksum at offset 3.
    always_comb begin
        w_pay_byte = 8'h00;
        for (int k = 0; k < MAX_PAYLOAD; k++) begin
            if (r_idx == IDX_W'(k + FRM_OFF_PAYLOAD)) begin
                w_pay_byte = r_payload[8*k +: 8];
            end
        end

        w_frame_byte = w_pay_byte;
        if (r_idx == IDX_W'(FRM_OFF_SYNC)) begin
            w_frame_byte = SYNC_BYTE;
        end else if (r_idx == IDX_W'(FRM_OFF_OPCODE)) begin
            w_frame_byte = r_opcode;
        end else if (r_idx == IDX_W'(FRM_OFF_LEN)) begin
            w_frame_byte = {4'h0, r_len};
        end else if (w_is_last) begin
            w_frame_byte = r_csum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // tx_done is checked ahead of the timeout so a done on the expiry cycle still advances.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next = ST_STROBE;
                end
            end
            ST_STROBE: begin
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    w_next = w_is_last ? ST_FINISH : ST_STROBE;
                end else if (w_tmo_hit) begin
                    w_next = ST_ABORT;
                end
            end
            ST_FINISH: begin
                w_next = ST_IDLE;
            end
            ST_ABORT: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_opcode    <= 8'h00;
            r_len       <= 4'h0;
            r_payload   <= '0;
            r_idx       <= '0;
            r_csum      <= 8'h00;
            r_tmo       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_tx_strobe <= 1'b0;
            r_wr_byte   <= 8'h00;
        end else begin
            r_tx_strobe <= (r_state == ST_STROBE);
            r_busy      <= (w_next == ST_STROBE) || (w_next == ST_WAIT);
            r_done      <= (w_next == ST_FINISH);
            r_error     <= (w_next == ST_ABORT);

            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_opcode  <= i_opcode;
                        r_len     <= (i_len > LEN_MAX) ? LEN_MAX : i_len;
                        r_payload <= i_payload;
                        r_idx     <= '0;
                        r_csum    <= 8'h00;
                        r_tmo     <= '0;
                    end
                end
                ST_STROBE: begin
                    r_wr_byte <= w_frame_byte;
                    r_tmo     <= '0;
                    if (w_fold) begin
                        r_csum <= csum_fold(r_csum, w_frame_byte);
                    end
                end
                ST_WAIT: begin
                    if (i_tx_done) begin
                        if (!w_is_last) begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_error     = r_error;
    assign o_tx_strobe = r_tx_strobe;
    assign o_wr_byte   = r_wr_byte;

endmodule

// File: tb/tb_cmd_response_tx.sv
// Bench for cmd_response_tx: uart_tx model answers each strobe with tx_done 1000 clk later,
// expected frame bytes are queued at start and popped on every strobe.
module tb_cmd_response_tx;
    import cmd_response_tx_pkg::*;

    localparam int MAXP     = 8;
    localparam int TMO      = 20000;
    localparam int DONE_DLY = 1000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              i_start = 1'b0;
    logic [7:0]        i_opcode = 8'h00;
    logic [3:0]        i_len = 4'h0;
    logic [MAXP*8-1:0] i_payload = '0;
    logic              i_tx_done = 1'b0;
    logic              o_busy;
    logic              o_done;
    logic              o_error;
    logic              o_tx_strobe;
    logic [7:0]        o_wr_byte;

    cmd_response_tx #(
        .MAX_PAYLOAD (MAXP),
        .SYNC_BYTE   (CMD_SYNC_BYTE),
        .TX_TIMEOUT  (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_start     (i_start),
        .i_opcode    (i_opcode),
        .i_len       (i_len),
        .i_payload   (i_payload),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error),
        .o_tx_strobe (o_tx_strobe),
        .o_wr_byte   (o_wr_byte),
        .i_tx_done   (i_tx_done)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    bit         withhold = 1'b0;
    int         done_cnt = 0;
    int         n_strobes = 0;
    int         frame_strobes = 0;
    int         last_strobe_cyc = 0;
    int         start_cyc = 0;
    bit         frame_first = 1'b0;
    int         n_done = 0;
    int         n_error = 0;
    int         done_cyc = 0;
    int         error_cyc = 0;
    logic [7:0] last_byte = 8'h00;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // uart_tx model plus output monitor, both evaluated on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            i_tx_done = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) i_tx_done = 1'b1;
            end
            if (o_tx_strobe === 1'b1) begin
                n_strobes++;
                frame_strobes++;
                if (frame_first) begin
                    check("sync_latency", 64'(cyc - start_cyc), 64'd2);
                    frame_first = 1'b0;
                end else begin
                    check("strobe_gap", 64'(cyc - last_strobe_cyc), 64'(DONE_DLY + 2));
                end
                last_strobe_cyc = cyc;
                last_byte = o_wr_byte;
                check("strobe_has_expected_byte", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    check("frame_byte", 64'(o_wr_byte), 64'(exp_q.pop_front()));
                end
                if (!withhold) done_cnt = DONE_DLY;
            end
            if (o_done === 1'b1) begin
                n_done++;
                done_cyc = cyc;
            end
            if (o_error === 1'b1) begin
                n_error++;
                error_cyc = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Queues the first n_push expected bytes (all when negative) and pulses i_start.
    task automatic start_frame(input logic [7:0] op, input logic [3:0] len,
                               input logic [MAXP*8-1:0] pay, input int n_push,
                               output int flen);
        logic [7:0] frame[$];
        logic [3:0] l;
        logic [7:0] cs;
        l  = (len > 4'(MAXP)) ? 4'(MAXP) : len;
        cs = op ^ {4'h0, l};
        frame.push_back(CMD_SYNC_BYTE);
        frame.push_back(op);
        frame.push_back({4'h0, l});
        for (int k = 0; k < int'(l); k++) begin
            frame.push_back(pay[8*k +: 8]);
            cs = cs ^ pay[8*k +: 8];
        end
        frame.push_back(cs);
        flen = frame.size();
        for (int k = 0; k < flen; k++) begin
            if (n_push < 0 || k < n_push) exp_q.push_back(frame[k]);
        end
        tick();
        i_opcode      = op;
        i_len         = len;
        i_payload     = pay;
        i_start       = 1'b1;
        start_cyc     = cyc;
        frame_first   = 1'b1;
        frame_strobes = 0;
        tick();
        i_start   = 1'b0;
        i_opcode  = 8'hEE;
        i_len     = 4'h7;
        i_payload = {MAXP{8'h5C}};
    endtask

    task automatic wait_end(input string tag, input int budget);
        int snap;
        int t;
        snap = n_done + n_error;
        t = 0;
        while ((n_done + n_error) == snap && t < budget) begin
            tick();
            t++;
        end
        check({tag, "_ended_in_budget"}, 64'((n_done + n_error) != snap), 64'd1);
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int t;
        t = 0;
        while (frame_strobes < n && t < budget) begin
            tick();
            t++;
        end
        check("strobe_reached_in_budget", 64'(frame_strobes >= n), 64'd1);
    endtask

    initial begin
        int flen;
        int snap_done;
        int snap_err;
        int snap_str;

        ticks(3);
        check("reset_outputs", 64'({o_busy, o_done, o_error, o_tx_strobe, o_wr_byte}), 64'h0);
        reset = 1'b0;
        ticks(2);

        // T1: ACK, no payload
        snap_err = n_error;
        start_frame(CMD_OP_ACK, 4'd0, '0, -1, flen);
        check("t1_busy_after_start", 64'(o_busy), 64'd1);
        wait_end("t1", 6000);
        check("t1_done_latency", 64'(done_cyc - last_strobe_cyc), 64'(DONE_DLY + 1));
        check("t1_busy_low_with_done", 64'(o_busy), 64'd0);
        check("t1_strobes", 64'(frame_strobes), 64'd4);
        check("t1_no_error", 64'(n_error - snap_err), 64'd0);
        tick();
        check("t1_done_pulse_width", 64'(o_done), 64'd0);
        ticks(5);

        // T2: STATUS with 3 payload bytes
        start_frame(CMD_OP_STATUS, 4'd3, 64'h0000_0000_0033_2211, -1, flen);
        wait_end("t2", 9000);
        check("t2_strobes", 64'(frame_strobes), 64'd7);
        check("t2_csum", 64'(last_byte), 64'h13);
        check("t2_queue_drained", 64'(exp_q.size()), 64'd0);
        ticks(5);

        // T3: oversize length clamps to MAX_PAYLOAD
        start_frame(8'h5A, 4'hF, 64'h8877_6655_4433_2211, -1, flen);
        wait_end("t3", 14000);
        check("t3_strobes", 64'(frame_strobes), 64'd12);
        check("t3_queue_drained", 64'(exp_q.size()), 64'd0);
        ticks(5);

        // T4: start while busy is ignored
        snap_done = n_done;
        start_frame(CMD_OP_STATUS, 4'd3, 64'h0000_0000_0033_2211, -1, flen);
        ticks(3);
        tick();
        i_opcode  = CMD_OP_NAK;
        i_len     = 4'd1;
        i_payload = 64'h99;
        i_start   = 1'b1;
        tick();
        i_start = 1'b0;
        wait_end("t4", 9000);
        check("t4_strobes", 64'(frame_strobes), 64'd7);
        check("t4_csum_unchanged", 64'(last_byte), 64'h13);
        snap_str = n_strobes;
        ticks(1200);
        check("t4_no_extra_frame", 64'(n_strobes - snap_str), 64'd0);
        check("t4_single_done", 64'(n_done - snap_done), 64'd1);

        // T5: uart_tx never answers the OPCODE byte
        snap_done = n_done;
        snap_err  = n_error;
        start_frame(CMD_OP_NAK, 4'd2, 64'hBEEF, 2, flen);
        wait_strobes(1, 10);
        withhold = 1'b1;
        wait_end("t5", TMO + 3000);
        check("t5_error_count", 64'(n_error - snap_err), 64'd1);
        check("t5_error_latency", 64'(error_cyc - last_strobe_cyc), 64'(TMO));
        check("t5_busy_low", 64'(o_busy), 64'd0);
        check("t5_no_done", 64'(n_done - snap_done), 64'd0);
        tick();
        check("t5_error_pulse_width", 64'(o_error), 64'd0);
        ticks(100);
        check("t5_no_further_strobes", 64'(frame_strobes), 64'd2);
        withhold = 1'b0;
        start_frame(CMD_OP_STATUS, 4'd1, 64'h42, -1, flen);
        wait_end("t5b", 7000);
        check("t5b_strobes", 64'(frame_strobes), 64'd5);
        check("t5b_csum", 64'(last_byte), 64'h53);
        ticks(5);

        // T6: reset while waiting on payload byte 1
        start_frame(CMD_OP_STATUS, 4'd3, 64'h00CC_BBAA, -1, flen);
        wait_strobes(5, 6000);
        ticks(10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_reset_outputs", 64'({o_busy, o_done, o_error, o_tx_strobe, o_wr_byte}), 64'h0);
        exp_q.delete();
        snap_str = n_strobes;
        ticks(1200);
        check("t6_late_done_ignored", 64'(n_strobes - snap_str), 64'd0);
        start_frame(CMD_OP_NAK, 4'd1, 64'h7E, -1, flen);
        wait_end("t6b", 7000);
        check("t6b_strobes", 64'(frame_strobes), 64'd5);
        check("t6b_csum", 64'(last_byte), 64'h7D);
        check("t6b_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
